s_pipenx_vr: RTL and testbench
==============================

Name: s_pipenx_vr

Overview:
- Parametrised elastic successor to the fixed n-clock delay line.
- Moves SIZE-bit words through DELAY register stages under a valid/ready handshake, with per-stage bubble collapsing, synchronous flush and an occupancy count.
- Sits between producer and consumer blocks that need a fixed minimum latency but may stall; it replaces free-running delay chains wherever back-pressure exists.

Parameters:
- SIZE, 8, data word width in bits (>=1).
- DELAY, 3, number of register stages (>=0); DELAY=0 means a combinational pass-through.
- RST_VAL, {SIZE{1'b0}}, reset value of every stage data register.
- CNTW, 2, width of occ; must satisfy 2^CNTW > DELAY.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of all stage valids.
- in_vld  input  1  producer word valid.
- in_rdy  output  1  block can accept in_dat this cycle.
- in_dat  input  SIZE  producer data.
- out_vld  output  1  last stage holds a valid word.
- out_rdy  input  1  consumer accepts out_dat this cycle.
- out_dat  output  SIZE  last-stage data.
- occ  output  CNTW  number of valid stages.

Behaviour:
- Clocking and reset: one clock domain; the reset is synchronous and active-high (rst sampled at the clk rising edge).
- Reset: all stage valids are 0 and all stage data registers equal RST_VAL. After reset, out_vld=0, out_dat=RST_VAL, occ=0 and in_rdy=1.
- Stage model: stages are numbered 0 (input side) to DELAY-1 (output side). Each stage k holds vld[k] and dat[k].
- Stage ready:
  - rdy[DELAY-1] = ~vld[DELAY-1] | out_rdy.
  - rdy[k] = ~vld[k] | rdy[k+1].
  - This ready chain is combinational; bubbles collapse, so an empty stage accepts even when downstream is stalled.
- in_rdy = rdy[0] & ~flush.
- Advance: when rdy[k]=1, at the edge vld[k] <= the valid of the upstream source (in_vld&in_rdy for stage 0, vld[k-1] otherwise). dat[k] loads the upstream data only when that upstream valid is 1; otherwise dat[k] holds.
- Hold: when rdy[k]=0, vld[k] and dat[k] hold.
- Outputs:
  - out_vld = vld[DELAY-1] & ~flush.
  - out_dat = dat[DELAY-1].
  - occ = popcount(vld). It is derived combinationally from the registers and is not gated by flush.
- Transfers: an input transfer is in_vld&in_rdy; an output transfer is out_vld&out_rdy.
- Latency: with out_rdy held at 1 and no flush, a word accepted at cycle t appears with out_vld=1 at cycle t+DELAY. Throughput is 1 word/cycle.
- Ordering: strict FIFO; no word is duplicated or dropped except by flush.
- Full condition: all DELAY vld set and out_rdy=0, so in_rdy=0. A simultaneous output transfer (out_rdy=1) keeps in_rdy=1 in the same cycle (pass-through of ready).
- Flush:
  - While flush=1, no input or output transfer occurs.
  - At the edge all vld <= 0; data registers hold.
  - occ reads 0 the cycle after flush.
  - flush together with rst: rst dominates, and data is reset to RST_VAL.
- Reset mid-operation: all in-flight words are discarded; the state equals the post-reset state above on the next cycle.
- DELAY=0: in_rdy = out_rdy & ~flush, out_vld = in_vld & ~flush, out_dat = in_dat, occ = 0; no registers.
- in_vld=1 with in_rdy=0: the word is not captured. The producer must hold in_vld and in_dat stable until accepted.
- Constraint: out_rdy must not depend combinationally on out_vld (avoids a loop through the ready chain).

Test Plan:
- Reset then stream: rst=1 for 2 cycles, then in_dat=0x01..0x0A on consecutive cycles with out_rdy=1 -> out_vld rises exactly 3 cycles after the first accept; out_dat=0x01..0x0A in order; occ steady at 3.
- Fill and stall: out_rdy=0, push 0x11,0x22,0x33,0x44 -> first 3 accepted; in_rdy=0 on the 4th; occ=3; out_dat=0x11. Then out_rdy=1 -> 0x11,0x22,0x33,0x44 emitted on 4 consecutive cycles.
- Bubble collapse: accept 0xA5, then 2 idle cycles, with out_rdy=0 -> 0xA5 reaches stage 2 and waits; then accept 0x5A -> 0x5A moves into stage 1 behind it (not held in stage 0); occ=2; no loss.
- Simultaneous pop at full: pipeline full of 0x01,0x02,0x03 with out_rdy=1 and in_vld=1 carrying 0x04 -> in_rdy=1; 0x01 leaves and 0x04 enters in the same cycle; occ stays 3.
- Flush mid-stream: occ=2, assert flush for 1 cycle with in_vld=1 and out_rdy=1 -> in_rdy=0 and out_vld=0 during flush; occ=0 next cycle; the word present during flush is never output.
- Reset mid-operation, plus DELAY=0 build: rst pulse while occ=3 -> next cycle occ=0, out_dat=RST_VAL. With DELAY=0 -> out_dat=in_dat and out_vld=in_vld in the same cycle; in_rdy follows out_rdy.

Source files
------------

// File: rtl/s_pipenx_vr.sv
// Elastic SIZE-bit delay line of DELAY register stages with valid/ready handshake,
// bubble collapsing, synchronous flush and an occupancy count.
module s_pipenx_vr #(
  parameter int unsigned     SIZE    = 8,
  parameter int unsigned     DELAY   = 3,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}},
  parameter int unsigned     CNTW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [SIZE-1:0] in_dat,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [SIZE-1:0] out_dat,
  output logic [CNTW-1:0] occ
);

  if (DELAY == 0) begin : g_pass
    // No storage: the handshake passes straight through.
    assign in_rdy  = out_rdy & ~flush;
    assign out_vld = in_vld & ~flush;
    assign out_dat = in_dat;
    assign occ     = '0;
  end else begin : g_pipe
    logic [DELAY-1:0] vld;
    logic [DELAY-1:0] rdy;
    logic [DELAY-1:0] up_vld;
    logic [SIZE-1:0]  dat    [DELAY];
    logic [SIZE-1:0]  up_dat [DELAY];

    // A stage is ready if it or any stage downstream of it is empty, or the consumer pops.
    always_comb begin
      logic acc;
      acc = out_rdy;
      for (int k = int'(DELAY) - 1; k >= 0; k--) begin
        acc    = acc | ~vld[k];
        rdy[k] = acc;
      end
    end

    assign in_rdy = rdy[0] & ~flush;

    always_comb begin
      up_vld[0] = in_vld & in_rdy;
      up_dat[0] = in_dat;
      for (int k = 1; k < int'(DELAY); k++) begin
        up_vld[k] = vld[k-1];
        up_dat[k] = dat[k-1];
      end
    end

    // Flush only clears valids; data registers keep their contents.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= '0;
        for (int k = 0; k < int'(DELAY); k++) begin
          dat[k] <= RST_VAL;
        end
      end else if (flush) begin
        vld <= '0;
      end else begin
        for (int k = 0; k < int'(DELAY); k++) begin
          if (rdy[k]) begin
            vld[k] <= up_vld[k];
            if (up_vld[k]) begin
              dat[k] <= up_dat[k];
            end
          end
        end
      end
    end

    always_comb begin
      occ = '0;
      for (int k = 0; k < int'(DELAY); k++) begin
        occ = occ + CNTW'(vld[k]);
      end
    end

    assign out_vld = vld[DELAY-1] & ~flush;
    assign out_dat = dat[DELAY-1];
  end

endmodule

// File: tb/tb_s_pipenx_vr.sv
// Self-checking bench for s_pipenx_vr: directed plan plus random traffic against a
// word/position queue model; a DELAY=0 instance is checked alongside.
module tb_s_pipenx_vr;
  localparam int D = 3;

  logic       clk;
  logic       rst, flush, in_vld, out_rdy;
  logic [7:0] in_dat;
  logic       in_rdy, out_vld;
  logic [7:0] out_dat;
  logic [1:0] occ;
  logic       in_rdy0, out_vld0;
  logic [7:0] out_dat0;
  logic [1:0] occ0;

  int checks = 0;
  int errors = 0;
  bit en = 0;

  typedef struct {
    logic [7:0] d;
    int         pos;
  } ent_t;
  ent_t       q[$];
  logic [7:0] last_dat = 8'h00;

  s_pipenx_vr #(.SIZE(8), .DELAY(D), .RST_VAL(8'h00), .CNTW(2)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_dat(in_dat), .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .occ(occ)
  );

  s_pipenx_vr #(.SIZE(8), .DELAY(0), .RST_VAL(8'h00), .CNTW(2)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy0),
    .in_dat(in_dat), .out_vld(out_vld0), .out_rdy(out_rdy), .out_dat(out_dat0), .occ(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, advance the model, take the edge.
  task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic fl, input logic rs, output logic acc);
    int         np[D];
    int         n, start, lim;
    logic       pop, e_ovld, e_irdy;
    rst = rs; flush = fl; in_vld = iv; in_dat = id; out_rdy = ordy;
    #2;
    n      = q.size();
    e_ovld = 1'b0;
    if (n > 0) e_ovld = (q[0].pos == D-1) && !fl;
    pop    = e_ovld && ordy;
    start  = pop ? 1 : 0;
    lim    = D-1;
    for (int i = start; i < n; i++) begin
      np[i] = (q[i].pos + 1 < lim) ? q[i].pos + 1 : lim;
      lim   = np[i] - 1;
    end
    e_irdy = !fl && ((n - start == 0) || (np[n-1] > 0));
    if (en) begin
      chk("in_rdy",  32'(in_rdy),  32'(e_irdy));
      chk("out_vld", 32'(out_vld), 32'(e_ovld));
      chk("out_dat", 32'(out_dat), 32'(last_dat));
      chk("occ",     32'(occ),     32'(n));
      chk("d0_in_rdy",  32'(in_rdy0),  32'(ordy & ~fl));
      chk("d0_out_vld", 32'(out_vld0), 32'(iv & ~fl));
      chk("d0_out_dat", 32'(out_dat0), 32'(id));
      chk("d0_occ",     32'(occ0),     32'(0));
    end
    acc = iv && e_irdy;
    if (rs) begin
      q.delete();
      last_dat = 8'h00;
    end else if (fl) begin
      q.delete();
    end else begin
      for (int i = start; i < n; i++) begin
        if (np[i] == D-1 && q[i].pos != D-1) last_dat = q[i].d;
        q[i].pos = np[i];
      end
      if (pop) void'(q.pop_front());
      if (iv && e_irdy) q.push_back('{d: id, pos: 0});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       a;
    logic       pv;
    logic [7:0] pd;
    logic       ordy, fl, rs;

    // Reset for two cycles; the second one already checks the post-reset state.
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, a);
    en = 1;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, a);
    chk("rst_out_vld", 32'(out_vld), 32'(0));
    chk("rst_out_dat", 32'(out_dat), 32'(8'h00));
    chk("rst_occ",     32'(occ),     32'(0));
    chk("rst_in_rdy",  32'(in_rdy),  32'(1));

    // Stream 0x01..0x0A with the consumer always ready.
    for (int i = 1; i <= 10; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, a);
    chk("stream_occ", 32'(occ), 32'(3));
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

    // Fill and stall, then release.
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, a);
    chk("full_occ",    32'(occ),    32'(3));
    chk("full_in_rdy", 32'(in_rdy), 32'(0));
    chk("full_head",   32'(out_dat), 32'(8'h11));
    cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, a);
    chk("full_reject", 32'(a), 32'(0));
    cycle(1'b1, 8'h44, 1'b1, 1'b0, 1'b0, a);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

    // Bubble collapse behind a stalled head word.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, a);
    chk("bubble_occ", 32'(occ), 32'(2));
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
    chk("bubble_occ2", 32'(occ), 32'(2));
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

    // Simultaneous pop and push while full.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, a);
    chk("passthru_acc", 32'(a),   32'(1));
    chk("passthru_occ", 32'(occ), 32'(3));
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

    // Flush with two words in flight.
    cycle(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, a);
    chk("flush_pre_occ", 32'(occ), 32'(2));
    cycle(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, a);
    chk("flush_occ", 32'(occ), 32'(0));
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

    // Reset while full.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
    chk("midrst_occ", 32'(occ),     32'(0));
    chk("midrst_dat", 32'(out_dat), 32'(8'h00));

    // Random traffic with a producer that holds its word until accepted.
    pv = 1'b0;
    pd = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (!pv && ($urandom_range(3) != 0)) begin
        pv = 1'b1;
        pd = 8'($urandom);
      end
      ordy = ($urandom_range(3) != 0);
      fl   = ($urandom_range(49) == 0);
      rs   = ($urandom_range(199) == 0);
      cycle(pv, pd, ordy, fl, rs, a);
      if (a) pv = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
